stump_bist_ctrl: RTL and testbench

- Sequencing controller for one STUMPS logic-BIST session: drives PRPG seed load and enable, scan-shift enable, capture pulses and MISR compaction.
- Runs a programmed number of patterns over scan chains of programmed length, then flags completion.
- Sits between the BIST register interface and the PRPG / scan-chain / MISR datapath.

---
 rtl/stump_bist_ctrl.sv | 158 +++++++++++++++
 tb/tb_stump_bist_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stump_bist_ctrl.sv
// STUMPS logic-BIST sequencer: seeds PRPG, shifts/captures P patterns
// of L cycles, compacts responses into the MISR, then flags done.
//
// Ports:
//   clk, internalRst_n           clock, async active-low reset
//   start, abort                 session control levels
//   chainLen, numPatterns        session config, latched at start
//   PRPG_Load, PRPG_En           PRPG seed-load pulse / advance enable
//   scanEn, captureEn            scan shift mode / capture pulse
//   MISR_Clr, MISR_En            MISR clear pulse / compaction enable
//   busy, done, patIdx           session status and current pattern
module stump_bist_ctrl #(
  parameter int LEN_W = 8,
  parameter int PAT_W = 16
) (
  input  logic             clk,
  input  logic             internalRst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] chainLen,
  input  logic [PAT_W-1:0] numPatterns,
  output logic             PRPG_Load,
  output logic             PRPG_En,
  output logic             scanEn,
  output logic             captureEn,
  output logic             MISR_Clr,
  output logic             MISR_En,
  output logic             busy,
  output logic             done,
  output logic [PAT_W-1:0] patIdx
);

  typedef enum logic [2:0] {
    IDLE, SEED, SHIFT, CAPTURE, UNLOAD, DONE
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [PAT_W-1:0] np_q, np_d;

  logic load_d, prpg_d, scan_d, cap_d;
  logic clr_d, misr_d, busy_d, done_d;

  logic last_shift;
  logic last_pat;

  // len_q holds the effective length (>=1), so L-1 never underflows.
  assign last_shift = (cnt_q == len_q - LEN_W'(1));
  assign last_pat   = (pat_q == np_q - PAT_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    len_d   = len_q;
    np_d    = np_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          len_d = (chainLen == '0) ? LEN_W'(1) : chainLen;
          np_d  = numPatterns;
          cnt_d = '0;
          pat_d = '0;
          state_d = (numPatterns == '0) ? DONE : SEED;
        end
      end
      SEED: begin
        cnt_d   = '0;
        pat_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (last_shift) begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      CAPTURE: begin
        cnt_d = '0;
        if (last_pat) begin
          state_d = UNLOAD;
        end else begin
          pat_d   = pat_q + PAT_W'(1);
          state_d = SHIFT;
        end
      end
      UNLOAD: begin
        if (last_shift) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      pat_d   = '0;
    end
  end

  // Outputs are decoded from the next state and registered, so each
  // output flop matches the state register in the same cycle.
  always_comb begin
    load_d = (state_d == SEED);
    clr_d  = (state_d == SEED);
    prpg_d = (state_d == SHIFT);
    scan_d = (state_d == SHIFT) || (state_d == UNLOAD);
    cap_d  = (state_d == CAPTURE);
    // Pattern 0's unload is the power-up chain content: not compacted.
    misr_d = ((state_d == SHIFT) && (pat_d != '0))
          || (state_d == UNLOAD);
    busy_d = (state_d == SEED) || (state_d == SHIFT)
          || (state_d == CAPTURE) || (state_d == UNLOAD);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge internalRst_n) begin
    if (!internalRst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      np_q      <= '0;
      PRPG_Load <= 1'b0;
      PRPG_En   <= 1'b0;
      scanEn    <= 1'b0;
      captureEn <= 1'b0;
      MISR_Clr  <= 1'b0;
      MISR_En   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      np_q      <= np_d;
      PRPG_Load <= load_d;
      PRPG_En   <= prpg_d;
      scanEn    <= scan_d;
      captureEn <= cap_d;
      MISR_Clr  <= clr_d;
      MISR_En   <= misr_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  assign patIdx = pat_q;

endmodule

// File: tb/tb_stump_bist_ctrl.sv
// Directed bench for stump_bist_ctrl: nominal run, edge configs,
// abort, start/config robustness and async reset mid-session.
module tb_stump_bist_ctrl;

  logic        clk = 1'b0;
  logic        internalRst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  chainLen = 8'd0;
  logic [15:0] numPatterns = 16'd0;
  logic        PRPG_Load, PRPG_En, scanEn, captureEn;
  logic        MISR_Clr, MISR_En, busy, done;
  logic [15:0] patIdx;

  int errors = 0;
  int checks = 0;

  int m_busy, m_prpg, m_cap_n, m_misr, m_load, m_clr, m_scan;
  int m_misr_first, m_done, m_end;
  int m_cap_at [4];
  int chg_at = 0;

  stump_bist_ctrl #(.LEN_W(8), .PAT_W(16)) dut (
    .clk(clk),
    .internalRst_n(internalRst_n),
    .start(start),
    .abort(abort),
    .chainLen(chainLen),
    .numPatterns(numPatterns),
    .PRPG_Load(PRPG_Load),
    .PRPG_En(PRPG_En),
    .scanEn(scanEn),
    .captureEn(captureEn),
    .MISR_Clr(MISR_Clr),
    .MISR_En(MISR_En),
    .busy(busy),
    .done(done),
    .patIdx(patIdx)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {PRPG_Load, PRPG_En, scanEn, captureEn,
            MISR_Clr, MISR_En, busy, done};
  endfunction

  // Raises start, then samples every cycle until done or budget.
  task automatic measure(input bit hold, input int maxc);
    m_busy = 0; m_prpg = 0; m_cap_n = 0; m_misr = 0;
    m_load = 0; m_clr = 0; m_scan = 0;
    m_misr_first = -1; m_done = 0; m_end = -1;
    for (int i = 0; i < 4; i++) m_cap_at[i] = -1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (chg_at == c) begin
        chainLen = 8'd1;
        numPatterns = 16'd7;
      end
      if (busy) m_busy++;
      if (PRPG_En) m_prpg++;
      if (captureEn) begin
        if (m_cap_n < 4) m_cap_at[m_cap_n] = c;
        m_cap_n++;
      end
      if (MISR_En) begin
        m_misr++;
        if (m_misr_first < 0) m_misr_first = c;
      end
      if (PRPG_Load) m_load++;
      if (MISR_Clr) m_clr++;
      if (scanEn) m_scan++;
      if (done) begin
        m_done = 1;
        m_end = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (outs() !== 8'h00 || patIdx !== 16'd0) begin
      errors++;
      $display("FAIL reset_hold got=%b/%0d exp=0/0", outs(), patIdx);
    end
    internalRst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (outs() !== 8'h00 || patIdx !== 16'd0) begin
      errors++;
      $display("FAIL reset_idle got=%b/%0d exp=0/0", outs(), patIdx);
    end
  endtask

  task automatic test_nominal();
    chainLen = 8'd4;
    numPatterns = 16'd3;
    measure(1'b0, 60);
    checks++;
    if (m_done !== 1 || m_end !== 21) begin
      errors++;
      $display("FAIL nom_done got=%0d@%0d exp=1@21", m_done, m_end);
    end
    checks++;
    if (m_busy !== 20) begin
      errors++;
      $display("FAIL nom_busy got=%0d exp=20", m_busy);
    end
    checks++;
    if (m_load !== 1 || m_clr !== 1) begin
      errors++;
      $display("FAIL nom_seed got=%0d/%0d exp=1/1", m_load, m_clr);
    end
    checks++;
    if (m_cap_n !== 3 || m_cap_at[0] !== 6 || m_cap_at[1] !== 11
        || m_cap_at[2] !== 16) begin
      errors++;
      $display("FAIL nom_capture got=%0d:%0d,%0d,%0d exp=3:6,11,16",
               m_cap_n, m_cap_at[0], m_cap_at[1], m_cap_at[2]);
    end
    checks++;
    if (m_prpg !== 12) begin
      errors++;
      $display("FAIL nom_prpg got=%0d exp=12", m_prpg);
    end
    checks++;
    if (m_misr !== 12 || m_misr_first !== 7) begin
      errors++;
      $display("FAIL nom_misr got=%0d first=%0d exp=12 first=7",
               m_misr, m_misr_first);
    end
    checks++;
    if (m_scan !== 16) begin
      errors++;
      $display("FAIL nom_scan got=%0d exp=16", m_scan);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || patIdx !== 16'd2) begin
      errors++;
      $display("FAIL nom_done_hold got=%b%b/%0d exp=10/2",
               done, busy, patIdx);
    end
  endtask

  task automatic test_zero_patterns();
    chainLen = 8'd4;
    numPatterns = 16'd0;
    measure(1'b0, 10);
    checks++;
    if (m_done !== 1 || m_end !== 1 || m_busy !== 0) begin
      errors++;
      $display("FAIL p0_done got=%0d@%0d busy=%0d exp=1@1 busy=0",
               m_done, m_end, m_busy);
    end
    checks++;
    if (m_load + m_prpg + m_scan + m_cap_n + m_misr + m_clr !== 0
        || patIdx !== 16'd0) begin
      errors++;
      $display("FAIL p0_activity got=%0d/%0d/%0d/%0d pat=%0d exp=0",
               m_load, m_prpg, m_scan, m_cap_n, patIdx);
    end
  endtask

  task automatic test_zero_len();
    chainLen = 8'd0;
    numPatterns = 16'd2;
    measure(1'b0, 20);
    checks++;
    if (m_done !== 1 || m_busy !== 6 || m_end !== 7) begin
      errors++;
      $display("FAIL l0_busy got=%0d@%0d busy=%0d exp=1@7 busy=6",
               m_done, m_end, m_busy);
    end
    checks++;
    if (m_cap_n !== 2 || m_cap_at[0] !== 3 || m_cap_at[1] !== 5
        || m_prpg !== 2 || m_misr !== 2) begin
      errors++;
      $display("FAIL l0_counts got=cap%0d@%0d,%0d prpg%0d misr%0d exp=cap2@3,5 prpg2 misr2",
               m_cap_n, m_cap_at[0], m_cap_at[1], m_prpg, m_misr);
    end
  endtask

  task automatic test_abort();
    chainLen = 8'd8;
    numPatterns = 16'd4;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (scanEn !== 1'b1 || PRPG_En !== 1'b1 || patIdx !== 16'd1) begin
      errors++;
      $display("FAIL abort_pre got=scan%b prpg%b pat%0d exp=1 1 1",
               scanEn, PRPG_En, patIdx);
    end
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if (outs() !== 8'h00 || patIdx !== 16'd0) begin
      errors++;
      $display("FAIL abort_idle got=%b/%0d exp=0/0", outs(), patIdx);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_stay got=%b%b exp=00", busy, done);
    end
    measure(1'b0, 80);
    checks++;
    if (m_done !== 1 || m_busy !== 45 || m_cap_n !== 4) begin
      errors++;
      $display("FAIL abort_rerun got=%0d busy=%0d cap=%0d exp=1 45 4",
               m_done, m_busy, m_cap_n);
    end
  endtask

  task automatic test_start_held();
    chainLen = 8'd4;
    numPatterns = 16'd3;
    chg_at = 5;
    measure(1'b1, 60);
    chg_at = 0;
    checks++;
    if (m_done !== 1 || m_busy !== 20 || m_cap_n !== 3) begin
      errors++;
      $display("FAIL held_len got=%0d busy=%0d cap=%0d exp=1 20 3",
               m_done, m_busy, m_cap_n);
    end
    @(negedge clk);
    checks++;
    if (PRPG_Load !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL held_reseed got=%b%b%b exp=110",
               PRPG_Load, busy, done);
    end
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_async_reset();
    chainLen = 8'd4;
    numPatterns = 16'd3;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (captureEn !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre got=%b exp=1", captureEn);
    end
    #2 internalRst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 8'h00 || patIdx !== 16'd0) begin
      errors++;
      $display("FAIL rst_async got=%b/%0d exp=0/0", outs(), patIdx);
    end
    @(negedge clk);
    internalRst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (outs() !== 8'h00) begin
      errors++;
      $display("FAIL rst_idle got=%b exp=0", outs());
    end
    measure(1'b0, 60);
    checks++;
    if (m_done !== 1 || m_busy !== 20) begin
      errors++;
      $display("FAIL rst_rerun got=%0d busy=%0d exp=1 20",
               m_done, m_busy);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_patterns();
    test_zero_len();
    test_abort();
    test_start_held();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
